// File: rtl/spi_slave_rsp_pkg.sv
// spi_rsp_pkg: shared types and constants for the SPI responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, idle fill word, default word type.
package spi_rsp_pkg;

  localparam int SPI_DW = 8;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_rsp_state_e;

  // Word sent when the master clocks a word the core never supplied.
  localparam logic [SPI_DW-1:0] SPI_IDLE_FILL = 8'hFF;

  typedef logic [SPI_DW-1:0] spi_word_t;

endpackage

// File: rtl/spi_slave_rsp_if.sv
// spi_slave_rsp_if: SPI pins, mode straps, TX/RX holding-register handshakes, status.
// Latency: n/a (wiring only).
// Backpressure: tx via tx_valid_i/tx_ready_o, rx via rx_valid_o/rx_ready_i.
// Modports: slave (the responder), master (SPI master + core-side user, i.e. the bench).
interface spi_slave_rsp_if #(
  parameter int DW = 8
);

  logic          sck_i;
  logic          ss_ni;
  logic          mosi_i;
  logic          miso_o;
  logic          miso_oe_o;
  logic          cpol_i;
  logic          cpha_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic          underrun_o;
  logic          overrun_o;
  logic          busy_o;

  modport slave (
    input  sck_i, ss_ni, mosi_i, cpol_i, cpha_i,
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output miso_o, miso_oe_o, tx_ready_o,
    output rx_data_o, rx_valid_o, underrun_o, overrun_o, busy_o
  );

  modport master (
    output sck_i, ss_ni, mosi_i, cpol_i, cpha_i,
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  miso_o, miso_oe_o, tx_ready_o,
    input  rx_data_o, rx_valid_o, underrun_o, overrun_o, busy_o
  );

endinterface

// File: rtl/spi_slave_rsp_sync.sv
// spi_sync: STAGES-deep flop synchronizer for one asynchronous input bit.
// Latency: STAGES clk_i cycles.
// Backpressure: none.
// Ports: clk_i, rst_ni (async active-low), d_i (async in), q_o (synchronized out).
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rsp.sv
// spi_slave_rsp: SPI responder, DW-bit MSB-first full duplex, all four CPOL/CPHA modes.
// Latency: sck edges act SYNC_STAGES+1 clk_i cycles after the pin moves; rx word valid the cycle after its last sample.
// Backpressure: single-entry TX/RX holding registers; empty TX sends fill + underrun, full RX drops + overrun.
// Ports: clk_i, rst_ni (async active-low), bus (spi_slave_rsp_if.slave).
// Build option: define SPI_SLAVE_RSP_LOOPBACK_EN to send the last received word instead of the fill on underrun.
module spi_slave_rsp
  import spi_rsp_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  spi_slave_rsp_if.slave bus
);

  localparam int            CW       = $clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW-1);

  logic sck_s, ss_s, mosi_s;
  logic sck_q, ss_q;

  // mosi shares the sck synchronizer depth so data and edge arrive together.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.sck_i), .q_o(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.ss_ni), .q_o(ss_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.mosi_i), .q_o(mosi_s)
  );

  spi_rsp_state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [DW-2:0] sr_rx_q;
  logic [DW-1:0] sr_tx_q;
  logic [DW-1:0] tx_hold_q;
  logic [DW-1:0] rx_data_q;
  logic          tx_full_q;
  logic          rx_valid_q;
  logic          miso_q;
  logic          under_q;
  logic          over_q;
  logic          uflag_q;
  logic          word_done_q;

  logic          rise, fall, lead, trail;
  logic          ss_fall, ss_rise;
  logic          load, drop, smp, shf, last;
  logic [DW-1:0] rx_word, fill, load_word;

  assign rise    = sck_s & ~sck_q;
  assign fall    = ~sck_s & sck_q;
  assign lead    = bus.cpol_i ? fall : rise;
  assign trail   = bus.cpol_i ? rise : fall;
  assign ss_fall = ss_q & ~ss_s;
  assign ss_rise = ~ss_q & ss_s;

  assign last      = smp && (cnt_q == LAST_BIT);
  assign rx_word   = {sr_rx_q, mosi_s};
  assign load_word = tx_full_q ? tx_hold_q : fill;

`ifdef SPI_SLAVE_RSP_LOOPBACK_EN
  logic [DW-1:0] lb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lb_q <= '0;
    end else if (last) begin
      lb_q <= rx_word;
    end
  end

  assign fill = lb_q;
`else
  assign fill = DW'(SPI_IDLE_FILL);
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    smp     = 1'b0;
    shf     = 1'b0;
    case (state_q)
      IDLE: begin
        // sck activity while deselected is ignored entirely.
        if (ss_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          drop    = 1'b1;
        end else if (word_done_q) begin
          load = 1'b1;
        end else begin
          smp = bus.cpha_i ? trail : lead;
          shf = bus.cpha_i ? lead : trail;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sck_q       <= 1'b0;
      ss_q        <= 1'b1;
      cnt_q       <= '0;
      sr_rx_q     <= '0;
      sr_tx_q     <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      uflag_q     <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_s;
      ss_q        <= ss_s;
      word_done_q <= last;
      under_q     <= 1'b0;
      over_q      <= 1'b0;

      // A write can only land while empty, so a write coinciding with a load
      // is kept for the word after the one being loaded.
      if (bus.tx_valid_i && !tx_full_q) begin
        tx_hold_q <= bus.tx_data_i;
        tx_full_q <= 1'b1;
      end else if (load) begin
        tx_full_q <= 1'b0;
      end

      if (load) begin
        cnt_q   <= '0;
        sr_rx_q <= '0;
        // Underrun is reported when the word's first bit is sampled, so the
        // speculative reload after a burst's final word stays silent.
        uflag_q <= !tx_full_q;
        if (!bus.cpha_i) begin
          miso_q  <= load_word[DW-1];
          sr_tx_q <= {load_word[DW-2:0], 1'b0};
        end else begin
          sr_tx_q <= load_word;
        end
      end else if (drop) begin
        cnt_q   <= '0;
        sr_rx_q <= '0;
        uflag_q <= 1'b0;
        miso_q  <= 1'b0;
      end else begin
        // In CPHA=0 the trailing edge that closes a word arrives after the
        // next word's MSB is already on miso; it must not shift.
        if (shf && (bus.cpha_i || (cnt_q != '0))) begin
          miso_q  <= sr_tx_q[DW-1];
          sr_tx_q <= {sr_tx_q[DW-2:0], 1'b0};
        end
        if (smp) begin
          sr_rx_q <= rx_word[DW-2:0];
          cnt_q   <= last ? '0 : cnt_q + 1'b1;
          if ((cnt_q == '0) && uflag_q) begin
            under_q <= 1'b1;
            uflag_q <= 1'b0;
          end
        end
      end

      if (last) begin
        if (rx_valid_q && !bus.rx_ready_i) begin
          over_q <= 1'b1;
        end else begin
          rx_data_q  <= rx_word;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.miso_o     = miso_q;
  assign bus.miso_oe_o  = (state_q == ACTIVE);
  assign bus.busy_o     = (state_q == ACTIVE);
  assign bus.tx_ready_o = !tx_full_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.underrun_o = under_q;
  assign bus.overrun_o  = over_q;

endmodule

// File: doc/spi_slave_rsp.md
Name: spi_slave_rsp

Overview:
- SPI slave (responder) that sits on the far end of the simple_spi master's sck/mosi/miso lines; used as the on-chip bench target and as a reusable peripheral.
- Oversamples sck_i, ss_ni and mosi_i on clk_i, runs 8-bit MSB-first full-duplex transfers in all four CPOL/CPHA modes.
- Offers a single-entry TX holding register and RX holding register, both with valid/ready handshakes, plus underrun and overrun flags.

Parameters:
- DW, 8, transfer word width in bits (MSB first).
- SYNC_STAGES, 2, synchronizer depth for sck_i, ss_ni and mosi_i (minimum 2).

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- sck_i  in  1  SPI serial clock from the master.
- ss_ni  in  1  slave select, active-low.
- mosi_i  in  1  master-out slave-in.
- miso_o  out  1  master-in slave-out.
- miso_oe_o  out  1  miso output enable; high only while selected.
- cpol_i  in  1  clock polarity; static while ss_ni is high.
- cpha_i  in  1  clock phase; static while ss_ni is high.
- tx_data_i  in  DW  next word to send.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX holding register empty.
- rx_data_o  out  DW  last received word.
- rx_valid_o  out  1  rx_data_o valid.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- underrun_o  out  1  one-cycle pulse: word started with TX register empty.
- overrun_o  out  1  one-cycle pulse: received word dropped.
- busy_o  out  1  slave selected (synchronized ss low).

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, underrun_o=0, overrun_o=0, busy_o=0. Bit counter and shift registers are cleared.
- Timing constraint: sck_i frequency must not exceed clk_i/8. Edges are detected after SYNC_STAGES+1 cycles.
- Edge definitions:
  - Leading edge = rising if cpol_i=0, falling if cpol_i=1.
  - cpha_i=0: sample on the leading edge, shift out on the trailing edge.
  - cpha_i=1: shift out on the leading edge, sample on the trailing edge.
- FSM IDLE -> ACTIVE:
  - Leaves IDLE on synchronized ss falling.
  - ACTIVE -> IDLE on synchronized ss rising, from any bit position.
- Word start (ss falling, or the cycle after bit DW-1 is sampled while ss stays low):
  - Shift register loads the TX holding register and tx_ready_o rises.
  - If the TX register is empty, load all-ones (8'hFF) and pulse underrun_o.
  - cpha_i=0: miso_o presents the MSB in the load cycle.
  - cpha_i=1: MSB is driven at the first leading edge.
- Bit counter: 0..DW-1, increments on each sample edge. After bit DW-1 is sampled:
  - Completed word goes to the RX register and rx_valid_o=1 the next cycle.
  - If rx_valid_o is still high and rx_ready_i is low that cycle, the new word is discarded, rx_data_o is unchanged, and overrun_o pulses.
  - If rx_ready_i and completion coincide, the old word is consumed, the new word is loaded, and there is no overrun.
- TX handshake: write when tx_valid_i && tx_ready_o; tx_ready_o falls the next cycle. A write in the same cycle as a word-start load is accepted for the following word.
- RX handshake: rx_valid_o falls the cycle after rx_valid_o && rx_ready_i, unless a new word lands that same cycle.
- ss deasserted mid-word:
  - Partial RX bits are discarded and the bit counter is cleared.
  - The loaded TX word is lost, not re-queued.
  - miso_oe_o=0 on the cycle after synchronized ss rises.
- Sampling: mosi_i is taken from the synchronizer stage aligned to sck_i, so edge and data have equal delay.
- Glitch handling: sck edges while ss is high are ignored.

Optional Feature:
- Macro SPI_SLAVE_RSP_LOOPBACK_EN.
- When defined, an underrun loads the last completed RX word, or 0 if none since reset, instead of 8'hFF. underrun_o still pulses.
- When undefined, an underrun loads 8'hFF. No loopback register is synthesized.

Decomposition:
- Package spi_rsp_pkg holds:
  - typedef enum {IDLE, ACTIVE} spi_rsp_state_e;
  - localparam SPI_IDLE_FILL = 8'hFF;
  - typedef logic [DW-1:0] spi_word_t (default 8).
- One sub-module, spi_sync: SYNC_STAGES flop synchronizer with async active-low reset. Instantiated three times, for sck_i, ss_ni and mosi_i.

Test Plan:
- Mode 0 (cpol=0, cpha=0), sck=clk/8: TX preload 0xA5, master sends 0x3C -> master reads 0xA5, rx_data_o=0x3C, rx_valid_o=1, no flags.
- Mode 3 (cpol=1, cpha=1): TX 0x81, master sends 0x7E -> master reads 0x81, rx_data_o=0x7E.
- ss held low for 2 words: TX 0x11 then 0x22 written between words, master sends 0xAA, 0x55 -> master reads 0x11, 0x22; RX returns 0xAA, then 0x55 after handshake.
- No TX write, master sends 0x00 -> master reads 0xFF (loopback off) and underrun_o pulses once. With the loopback macro defined and prior RX 0x3C, master reads 0x3C.
- rx_ready_i held 0, two words 0x01, 0x02 -> rx_data_o stays 0x01 and overrun_o pulses once. With rx_ready_i=1 on the completion cycle, no overrun.
- ss raised after 3 bits, then a full word 0xC3 -> no rx_valid_o for the partial word, rx_data_o=0xC3, and miso_oe_o=0 while deselected.
